// File: rtl/spi_pkg.sv
// Constants shared by the SPI transmit and receive controllers.
package spi_pkg;

  localparam int SPI_DATA_WIDTH   = 8;
  localparam int SPI_SYNC_STAGES  = 2;
  localparam int SPI_IDLE_TIMEOUT = 32;
  localparam int SYS_CLK_HZ       = 100_000_000;
  localparam int SPI_CLK_MAX_HZ   = 10_000_000;

  // Two-state view of the receiver, decoded from the bit counter.
  typedef enum logic {
    RX_IDLE  = 1'b0,  // bit_cnt == 0, no partial word
    RX_SHIFT = 1'b1   // bit_cnt != 0, partial word in progress
  } rx_state_e;

endpackage

// File: rtl/spi_rx_sync.sv
// Synchronizes the asynchronous SPI clock and data into the system clock
// domain and detects rising edges of the synchronized SPI clock.
// Both chains have the same depth so data stays aligned with its clock.
// SYNC_STAGES must be at least 2.
module spi_rx_sync
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic spi_clock_i,
  input  logic spi_data_i,
  output logic sclk_rise_o,
  output logic data_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   sclk_prev_q;

  // Synchronizer chains plus the previous-sclk flop for edge detection.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      data_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its predecessor, so the chain really is SYNC_STAGES flops deep.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clock_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], spi_data_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_o = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign data_o      = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_rx_control.sv
// SPI receiver: assembles MSB-first words from the synchronized SPI stream,
// hands them downstream through a valid/ready holding register, flags
// dropped words (overrun) and discards stalled partial words (frame error).
module spi_rx_control
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH   = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES  = SPI_SYNC_STAGES,
  parameter int IDLE_TIMEOUT = SPI_IDLE_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  spi_clock,
  input  logic                  spi_data_in,
  input  logic                  rx_ready,
  input  logic                  rx_overrun_clr,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_overrun,
  output logic                  rx_busy,
  output logic                  frame_error
);

  localparam int CNT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int IDLE_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT - 1);

  logic                  sclk_rise;
  logic                  sdata;
  rx_state_e             state;
  logic                  word_done;
  logic                  consume;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] shift_q,       shift_d;
  logic [CNT_W-1:0]      bit_cnt_q,     bit_cnt_d;
  logic [IDLE_W-1:0]     idle_q,        idle_d;
  logic [DATA_WIDTH-1:0] rx_data_q,     rx_data_d;
  logic                  rx_valid_q,    rx_valid_d;
  logic                  rx_overrun_q,  rx_overrun_d;
  logic                  rx_busy_q,     rx_busy_d;
  logic                  frame_error_q, frame_error_d;

  spi_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .spi_clock_i(spi_clock),
    .spi_data_i (spi_data_in),
    .sclk_rise_o(sclk_rise),
    .data_o     (sdata)
  );

  // Next-state logic: shifting, idle timeout and the output handshake.
  always_comb begin
    // NOTE: every target gets its hold value first, so no path through the
    // branches below can leave one unassigned and infer a latch.
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    idle_d        = idle_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = rx_overrun_q;
    frame_error_d = 1'b0;

    state     = (bit_cnt_q == '0) ? RX_IDLE : RX_SHIFT;
    word_done = sclk_rise && (bit_cnt_q == LAST_BIT);
    consume   = rx_valid_q && rx_ready;
    timeout   = !sclk_rise && (state == RX_SHIFT) && (idle_q == IDLE_LIMIT);

    // Bit assembly and idle supervision of a partial word.
    if (sclk_rise) begin
      shift_d   = {shift_q[DATA_WIDTH-2:0], sdata};
      bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
      idle_d    = '0;
    end else if (timeout) begin
      shift_d       = '0;
      bit_cnt_d     = '0;
      idle_d        = '0;
      frame_error_d = 1'b1;
    end else if (state == RX_IDLE) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    // Holding register: a consume frees the slot, a completion on the same
    // edge refills it; a completion into an occupied slot is dropped.
    if (consume) begin
      rx_valid_d = 1'b0;
    end
    if (word_done) begin
      if (!rx_valid_q || consume) begin
        rx_data_d  = {shift_q[DATA_WIDTH-2:0], sdata};
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end

    // A new overrun on the clearing edge wins over the clear.
    if (rx_overrun_clr && !(word_done && rx_valid_q && !consume)) begin
      rx_overrun_d = 1'b0;
    end

    rx_busy_d = (bit_cnt_d != '0);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      idle_q        <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      rx_busy_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      idle_q        <= idle_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      rx_busy_q     <= rx_busy_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign rx_busy     = rx_busy_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_rx_control.sv
// Directed bench for spi_rx_control: SPI bits are driven at 10 MHz
// (5 system clocks per half period); outputs are sampled on falling clock.
module tb_spi_rx_control;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       spi_clock;
  logic       spi_data_in;
  logic       rx_ready;
  logic       rx_overrun_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_busy;
  logic       frame_error;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] vlog[$];
  int         fe_cnt = 0;

  spi_rx_control dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .spi_clock     (spi_clock),
    .spi_data_in   (spi_data_in),
    .rx_ready      (rx_ready),
    .rx_overrun_clr(rx_overrun_clr),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_overrun    (rx_overrun),
    .rx_busy       (rx_busy),
    .frame_error   (frame_error)
  );

  always #5 clock = ~clock;

  // Log every cycle rx_valid is high and every frame_error cycle.
  always @(negedge clock) begin
    if (rx_valid === 1'b1) vlog.push_back(rx_data);
    if (frame_error === 1'b1) fe_cnt++;
  end

  // Data and low phase of one bit, ending with spi_clock raised.
  task automatic bit_rise(input logic d);
    spi_data_in = d;
    spi_clock   = 1'b0;
    repeat (5) @(negedge clock);
    spi_clock = 1'b1;
  endtask

  task automatic send_bit(input logic d);
    bit_rise(d);
    repeat (5) @(negedge clock);
    spi_clock = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; spi_clock = 1'b0; spi_data_in = 1'b0;
    rx_ready = 1'b0; rx_overrun_clr = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_cmp++; if ({rx_valid, rx_overrun, rx_busy, frame_error} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {rx_valid, rx_overrun, rx_busy, frame_error}); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_byte();
    logic [7:0] b = 8'hA5;
    int bad = 0;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    bit_rise(b[0]);                      // next posedge is edge k
    @(negedge clock);                    // after k
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL latency_k: valid got %b want 0", rx_valid); end
    @(negedge clock);                    // after k+1
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL latency_k1: valid got %b want 0", rx_valid); end
    @(negedge clock);                    // after k+2
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin n_err++; $display("FAIL latency_k2: valid/data got %b/%h want 1/a5", rx_valid, rx_data); end
    repeat (2) @(negedge clock);
    spi_clock = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (rx_valid !== 1'b1 || rx_data !== 8'hA5) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL hold_a5: %0d bad cycles, want 0", bad); end
    consume();
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL consume_a5: valid got %b want 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    rx_ready = 1'b1;
    vlog.delete();
    send_word(8'h3C);
    send_word(8'hC3);
    repeat (5) @(negedge clock);
    rx_ready = 1'b0;
    n_cmp++; if (vlog.size() !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d valid cycles want 2", vlog.size()); end
    if (vlog.size() >= 2) begin
      n_cmp++; if (vlog[0] !== 8'h3C) begin n_err++; $display("FAIL b2b_first: got %h want 3c", vlog[0]); end
      n_cmp++; if (vlog[1] !== 8'hC3) begin n_err++; $display("FAIL b2b_second: got %h want c3", vlog[1]); end
    end
    n_cmp++; if (rx_overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", rx_overrun); end
  endtask

  task automatic test_overrun();
    send_word(8'h11);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h11 || rx_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first: valid/data/ovr got %b/%h/%b want 1/11/0", rx_valid, rx_data, rx_overrun); end
    send_word(8'h22);
    n_cmp++; if (rx_data !== 8'h11) begin n_err++; $display("FAIL ovr_keep: data got %h want 11", rx_data); end
    n_cmp++; if (rx_overrun !== 1'b1 || rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_flag: ovr/valid got %b/%b want 1/1", rx_overrun, rx_valid); end
    rx_overrun_clr = 1'b1;
    @(negedge clock);
    rx_overrun_clr = 1'b0;
    n_cmp++; if (rx_overrun !== 1'b0 || rx_data !== 8'h11) begin n_err++; $display("FAIL ovr_clear: ovr/data got %b/%h want 0/11", rx_overrun, rx_data); end
    consume();
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovr_consume: valid got %b want 0", rx_valid); end
  endtask

  task automatic test_timeout();
    int   fe_at = -1;
    int   fe_before;
    logic busy_mid = 1'b0;
    repeat (4) send_bit(1'b1);
    bit_rise(1'b1);                      // fifth bit, next posedge is edge k
    fe_before = fe_cnt;
    for (int j = 1; j <= 60 && fe_at < 0; j++) begin
      @(negedge clock);
      if (j == 5) spi_clock = 1'b0;
      if (j == 10) busy_mid = rx_busy;
      if (frame_error === 1'b1) fe_at = j;
    end
    n_cmp++; if (busy_mid !== 1'b1) begin n_err++; $display("FAIL to_busy_mid: got %b want 1", busy_mid); end
    n_cmp++; if (fe_at !== 35) begin n_err++; $display("FAIL to_timing: frame_error at sample %0d want 35", fe_at); end
    @(negedge clock);
    n_cmp++; if (frame_error !== 1'b0 || rx_busy !== 1'b0) begin n_err++; $display("FAIL to_pulse: fe/busy got %b/%b want 0/0", frame_error, rx_busy); end
    repeat (40) @(negedge clock);
    n_cmp++; if (fe_cnt - fe_before !== 1) begin n_err++; $display("FAIL to_count: got %0d pulses want 1", fe_cnt - fe_before); end
    n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h11) begin n_err++; $display("FAIL to_untouched: valid/data got %b/%h want 0/11", rx_valid, rx_data); end
    send_word(8'h81);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin n_err++; $display("FAIL to_next: valid/data got %b/%h want 1/81", rx_valid, rx_data); end
    consume();
  endtask

  task automatic test_mid_reset();
    int fe_before;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL rst_busy_before: got %b want 1", rx_busy); end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", rx_data); end
    n_cmp++; if ({rx_valid, rx_overrun, rx_busy, frame_error} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {rx_valid, rx_overrun, rx_busy, frame_error}); end
    fe_before = fe_cnt;
    send_word(8'h5A);
    repeat (40) @(negedge clock);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin n_err++; $display("FAIL rst_next: valid/data got %b/%h want 1/5a", rx_valid, rx_data); end
    n_cmp++; if (fe_cnt !== fe_before) begin n_err++; $display("FAIL rst_no_fe: got %0d pulses want 0", fe_cnt - fe_before); end
  endtask

  task automatic test_consume_on_completion();
    logic [7:0] b = 8'h77;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    bit_rise(b[0]);                      // next posedge is edge k
    repeat (2) @(negedge clock);         // after k+1
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin n_err++; $display("FAIL same_pre: valid/data got %b/%h want 1/5a", rx_valid, rx_data); end
    rx_ready = 1'b1;
    @(negedge clock);                    // after k+2: consume and completion
    rx_ready = 1'b0;
    n_cmp++; if (rx_data !== 8'h77) begin n_err++; $display("FAIL same_data: got %h want 77", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1 || rx_overrun !== 1'b0) begin n_err++; $display("FAIL same_flags: valid/ovr got %b/%b want 1/0", rx_valid, rx_overrun); end
    repeat (2) @(negedge clock);
    spi_clock = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_timeout();
    test_mid_reset();
    test_consume_on_completion();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
